uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with an input FIFO and valid/ready handshake.
//  It replaces the fixed 8N1 transmitter on the peripheral bus. The CPU-side

---
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake of the UART transmitter: words offered with valid,
// accepted while ready is high.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input  tx_ready);
  modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO; frames go out LSB first and
// back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter  int CLKS_PER_BIT = 10416,
  parameter  int DATA_BITS    = 8,
  parameter  int PARITY       = 0,
  parameter  int STOP_BITS    = 1,
  parameter  int FIFO_DEPTH   = 16,
  localparam int AW           = $clog2(FIFO_DEPTH)
) (
  input  logic          UART_CLK,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic          tx,
  output logic          tx_busy,
  output logic [AW:0]   fifo_count,
  output logic          fifo_empty,
  output logic          fifo_full
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop;

  state_t               state_q;
  logic                 tx_q;
  logic [BW-1:0]        baud_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q, head;
  logic                 par_q, par_head;
  logic                 baud_last, stop_last;

  assign fifo_count   = count_q;
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
  assign bus.tx_ready = !fifo_full;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != S_IDLE);

  assign head      = mem[rd_ptr_q];
  assign par_head  = (PARITY == 1) ? ~(^head) : (^head);
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign stop_last = (state_q == S_STOP) && baud_last && (bit_q == 4'(STOP_BITS - 1));

  // A word leaves the FIFO only when a new frame starts, so the frame in
  // flight never sees later pushes.
  always_comb begin
    push     = bus.tx_valid && bus.tx_ready;
    pop      = !fifo_empty && ((state_q == S_IDLE) || stop_last);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge UART_CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge UART_CLK) begin
    if (push) mem[wr_ptr_q] <= bus.tx_data;
  end

  always_ff @(posedge UART_CLK) begin
    if (pop) begin
      shift_q <= head;
      par_q   <= par_head;
    end else if (state_q == S_DATA && baud_last) begin
      shift_q <= shift_q >> 1;
    end
  end

  always_ff @(posedge UART_CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      baud_q <= (baud_last || state_q == S_IDLE) ? '0 : baud_q + BW'(1);
      case (state_q)
        S_IDLE: begin
          bit_q <= '0;
          tx_q  <= 1'b1;
          if (pop) begin
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            if (bit_q == 4'(DATA_BITS - 1)) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
              tx_q  <= shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (baud_last) begin
            tx_q    <= 1'b1;
            bit_q   <= '0;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            if (bit_q == 4'(STOP_BITS - 1)) begin
              bit_q <= '0;
              if (pop) begin
                tx_q    <= 1'b0;
                state_q <= S_START;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three builds (8N1, 7E2, 8O1) at four
// clocks per bit, checked bit by bit against hand-computed frames.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if2 ();

  logic       tx0, tx1, tx2, busy0, busy1, busy2;
  logic [4:0] cnt0, cnt1, cnt2;
  logic       emp0, emp1, emp2, full0, full1, full2;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
    .UART_CLK(clk), .reset(reset), .bus(if0), .tx(tx0), .tx_busy(busy0),
    .fifo_count(cnt0), .fifo_empty(emp0), .fifo_full(full0));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut1 (
    .UART_CLK(clk), .reset(reset), .bus(if1), .tx(tx1), .tx_busy(busy1),
    .fifo_count(cnt1), .fifo_empty(emp1), .fifo_full(full1));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut2 (
    .UART_CLK(clk), .reset(reset), .bus(if2), .tx(tx2), .tx_busy(busy2),
    .fifo_count(cnt2), .fifo_empty(emp2), .fifo_full(full2));

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          which;
    logic [8:0]  data;
    logic [15:0] frame;
    int          nbits;
    string       name;
  } vec_t;

  vec_t vecs[10];

  function automatic logic tx_of(input int w);
    return (w == 0) ? tx0 : (w == 1) ? tx1 : tx2;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
  endfunction

  function automatic logic [4:0] cnt_of(input int w);
    return (w == 0) ? cnt0 : (w == 1) ? cnt1 : cnt2;
  endfunction

  function automatic logic emp_of(input int w);
    return (w == 0) ? emp0 : (w == 1) ? emp1 : emp2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called one negedge before the edge that should capture the word.
  task automatic push(input int which, input logic [8:0] d);
    case (which)
      0: begin if0.tx_valid = 1'b1; if0.tx_data = d[7:0]; end
      1: begin if1.tx_valid = 1'b1; if1.tx_data = d[6:0]; end
      default: begin if2.tx_valid = 1'b1; if2.tx_data = d[7:0]; end
    endcase
    @(negedge clk);
    if0.tx_valid = 1'b0;
    if1.tx_valid = 1'b0;
    if2.tx_valid = 1'b0;
  endtask

  // Entered on the negedge inside the first start-bit cycle; returns on the
  // negedge right after the last stop-bit cycle.
  task automatic check_frame(input int which, input logic [15:0] bits, input int nbits, input string name);
    for (int b = 0; b < nbits; b++) begin
      logic act;
      act = tx_of(which);
      for (int c = 0; c < CPB; c++) begin
        if (tx_of(which) !== bits[b]) act = tx_of(which);
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", name, b), {31'b0, act}, {31'b0, bits[b]});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  initial begin
    // frame bit 0 is the start bit, transmitted first
    vecs[0] = '{0, 9'h0A5, 16'h034A, 10, "a5_8n1"};
    vecs[1] = '{0, 9'h03C, 16'h0278, 10, "3c_8n1"};
    vecs[2] = '{0, 9'h0FF, 16'h03FE, 10, "ff_8n1"};
    vecs[3] = '{0, 9'h000, 16'h0200, 10, "00_8n1"};
    vecs[4] = '{1, 9'h013, 16'h0726, 11, "13_7e2"};
    vecs[5] = '{1, 9'h07F, 16'h07FE, 11, "7f_7e2"};
    vecs[6] = '{1, 9'h000, 16'h0600, 11, "00_7e2"};
    vecs[7] = '{2, 9'h000, 16'h0600, 11, "00_8o1"};
    vecs[8] = '{2, 9'h001, 16'h0402, 11, "01_8o1"};
    vecs[9] = '{2, 9'h0A5, 16'h074A, 11, "a5_8o1"};

    if0.tx_valid = 1'b0; if0.tx_data = '0;
    if1.tx_valid = 1'b0; if1.tx_data = '0;
    if2.tx_valid = 1'b0; if2.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx0}, 32'd1);
    chk("rst_busy", {31'b0, busy0}, 32'd0);
    chk("rst_count", {27'b0, cnt0}, 32'd0);
    chk("rst_empty", {31'b0, emp0}, 32'd1);
    chk("rst_full", {31'b0, full0}, 32'd0);
    chk("rst_ready", {31'b0, if0.tx_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      push(vecs[i].which, vecs[i].data);
      chk({vecs[i].name, "_idle_at_push"}, {31'b0, tx_of(vecs[i].which)}, 32'd1);
      chk({vecs[i].name, "_count_at_push"}, {27'b0, cnt_of(vecs[i].which)}, 32'd1);
      @(negedge clk);
      chk({vecs[i].name, "_busy_start"}, {31'b0, busy_of(vecs[i].which)}, 32'd1);
      check_frame(vecs[i].which, vecs[i].frame, vecs[i].nbits, vecs[i].name);
      chk({vecs[i].name, "_busy_end"}, {31'b0, busy_of(vecs[i].which)}, 32'd0);
      chk({vecs[i].name, "_empty_end"}, {31'b0, emp_of(vecs[i].which)}, 32'd1);
      @(negedge clk);
    end

    // reset in the middle of data bit 3 with a second word queued
    push(0, 9'h0A5);
    push(0, 9'h03C);
    repeat (17) @(negedge clk);
    chk("mid_busy_before_rst", {31'b0, busy0}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_tx", {31'b0, tx0}, 32'd1);
    chk("midrst_busy", {31'b0, busy0}, 32'd0);
    chk("midrst_count", {27'b0, cnt0}, 32'd0);
    chk("midrst_ready", {31'b0, if0.tx_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", {30'b0, busy0, tx0}, 32'd1);
    push(0, 9'h05A);
    @(negedge clk);
    check_frame(0, 16'h02B4, 10, "5a_after_rst");
    chk("5a_busy_end", {31'b0, busy0}, 32'd0);

    // 17 back-to-back pushes: first starts a frame, the other 16 fill the FIFO
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          if0.tx_valid = 1'b1;
          if0.tx_data  = 8'(8'h30 + i);
          @(negedge clk);
        end
        if0.tx_valid = 1'b0;
        chk("burst_full", {31'b0, full0}, 32'd1);
        chk("burst_ready", {31'b0, if0.tx_ready}, 32'd0);
        chk("burst_count", {27'b0, cnt0}, 32'd16);
        if0.tx_valid = 1'b1;
        if0.tx_data  = 8'hFF;
        @(negedge clk);
        if0.tx_valid = 1'b0;
        chk("burst_drop_count", {27'b0, cnt0}, 32'd16);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
          logic [7:0] d;
          d = 8'(8'h30 + i);
          check_frame(0, {6'b0, 1'b1, d, 1'b0}, 10, $sformatf("burst%0d", i));
        end
        chk("burst_busy_end", {31'b0, busy0}, 32'd0);
        chk("burst_empty_end", {31'b0, emp0}, 32'd1);
      end
    join
    @(negedge clk);

    // push landing on the STOP-to-START pop edge, pointers already wrapped
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          if0.tx_valid = 1'b1;
          if0.tx_data  = 8'(8'hC0 + i);
          @(negedge clk);
        end
        if0.tx_valid = 1'b0;
        chk("wrap_count3", {27'b0, cnt0}, 32'd3);
        repeat (37) @(negedge clk);
        chk("wrap_count_pre", {27'b0, cnt0}, 32'd3);
        if0.tx_valid = 1'b1;
        if0.tx_data  = 8'hC4;
        @(negedge clk);
        if0.tx_valid = 1'b0;
        chk("wrap_count_same_edge", {27'b0, cnt0}, 32'd3);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          logic [7:0] d;
          d = 8'(8'hC0 + i);
          check_frame(0, {6'b0, 1'b1, d, 1'b0}, 10, $sformatf("wrap%0d", i));
        end
        chk("wrap_busy_end", {31'b0, busy0}, 32'd0);
        chk("wrap_empty_end", {31'b0, emp0}, 32'd1);
      end
    join

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
